midi_uart_tx: RTL and testbench

MIDI serial transmitter on the pll_clk_in (8 MHz) domain. It consumes the MIDI clock bus (midi_clock, keep_alive, midi_rst) and buffers outgoing bytes in a FIFO. Each byte is serialised as 8N1 at 31.25 kbaud onto tx_out, and a 0xFE Active Sensing byte is inserted when the line has been quiet. It sits directly downstream of the MIDI clock generator, one instance per MIDI OUT port.

---
 rtl/midi_pkg.sv | 14 +
 rtl/midi_tx_fifo.sv | 56 +++++
 rtl/midi_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_midi_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and the transmitter state encoding.
package midi_pkg;

    localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;
    localparam int         MIDI_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/midi_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with full/empty flags and a fill level.
module midi_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                                 pll_clk_in,
    input  logic                                 rst,
    input  logic [midi_pkg::MIDI_DATA_BITS-1:0]  wr_data,
    input  logic                                 wr_en,
    input  logic                                 rd_en,
    output logic [midi_pkg::MIDI_DATA_BITS-1:0]  rd_data,
    output logic                                 full,
    output logic                                 empty,
    output logic [DEPTH_LOG2:0]                  level
);
    import midi_pkg::*;

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [MIDI_DATA_BITS-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]     wr_ptr;
    logic [DEPTH_LOG2-1:0]     rd_ptr;
    logic [DEPTH_LOG2:0]       count;
    logic                      wr_ok;
    logic                      rd_ok;

    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pll_clk_in) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge pll_clk_in) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI OUT serialiser: FIFO-buffered 8N1 frames, one bit per synced midi_clock rise.
// Define MIDI_TX_ACTIVE_SENSE_EN to insert 0xFE Active Sensing when the line has been quiet.
module midi_uart_tx #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     pll_clk_in,
    input  logic                     rst,
    input  logic                     midi_clock,
    input  logic                     keep_alive,
    input  logic                     midi_rst,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     tx_out,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     sense_sent
);
    import midi_pkg::*;

    localparam logic [2:0] BIT_LAST = 3'(MIDI_DATA_BITS - 1);

    logic       mc_s1, mc_s2, mc_d, tick;
    logic       mr_s1, mr_s2, rst_int;
    logic       fifo_wr, fifo_full, fifo_empty;
    logic [7:0] fifo_data;
    logic       load_slot, load_fifo, load_sense;
    tx_state_t  state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    // Clock-bus inputs are asynchronous: two sync stages, then a registered rising-edge detect.
    always_ff @(posedge pll_clk_in) begin
        if (rst) begin
            mc_s1 <= 1'b0;
            mc_s2 <= 1'b0;
            mc_d  <= 1'b0;
            tick  <= 1'b0;
            mr_s1 <= 1'b0;
            mr_s2 <= 1'b0;
        end else begin
            mc_s1 <= midi_clock;
            mc_s2 <= mc_s1;
            mc_d  <= mc_s2;
            tick  <= mc_s2 & ~mc_d;
            mr_s1 <= midi_rst;
            mr_s2 <= mr_s1;
        end
    end

    assign rst_int = rst | mr_s2;
    assign s_ready = !fifo_full && !rst_int;
    assign fifo_wr = s_valid && s_ready;

    midi_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .pll_clk_in (pll_clk_in),
        .rst        (rst_int),
        .wr_data    (s_data),
        .wr_en      (fifo_wr),
        .rd_en      (load_fifo),
        .rd_data    (fifo_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    // A new frame may only start at a byte boundary: from IDLE or at the end of a stop bit.
    assign load_slot = tick && (state == IDLE || state == STOP);
    assign load_fifo = load_slot && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;

`ifdef MIDI_TX_ACTIVE_SENSE_EN
    logic ka_s1, ka_s2, ka_d, ka_pulse;
    logic activity, sense_pending;

    always_ff @(posedge pll_clk_in) begin
        if (rst) begin
            ka_s1    <= 1'b0;
            ka_s2    <= 1'b0;
            ka_d     <= 1'b0;
            ka_pulse <= 1'b0;
        end else begin
            ka_s1    <= keep_alive;
            ka_s2    <= ka_s1;
            ka_d     <= ka_s2;
            ka_pulse <= ka_s2 & ~ka_d;
        end
    end

    // Later assignments win: a new keep-alive request survives a same-cycle sense load,
    // and a same-cycle data load leaves activity set.
    always_ff @(posedge pll_clk_in) begin
        if (rst_int) begin
            activity      <= 1'b0;
            sense_pending <= 1'b0;
        end else begin
            if (load_sense) sense_pending <= 1'b0;
            if (ka_pulse) begin
                if (!activity) sense_pending <= 1'b1;
                activity <= 1'b0;
            end
            if (load_fifo) activity <= 1'b1;
        end
    end

    assign load_sense = load_slot && fifo_empty && sense_pending;
`else
    logic unused_keep_alive;
    assign unused_keep_alive = keep_alive;
    assign load_sense        = 1'b0;
`endif

    always_ff @(posedge pll_clk_in) begin
        if (rst_int) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            sense_sent <= 1'b0;
        end else begin
            sense_sent <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE, STOP: begin
                        if (load_fifo) begin
                            tx_out <= 1'b0;
                            shreg  <= fifo_data;
                            state  <= START;
                        end else if (load_sense) begin
                            tx_out     <= 1'b0;
                            shreg      <= MIDI_ACTIVE_SENSE;
                            state      <= START;
                            sense_sent <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    START: begin
                        tx_out  <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            tx_out <= 1'b1;
                            state  <= STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            tx_out  <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx: frame shape, back-to-back, FIFO full, midi_rst abort, keep-alive.
`timescale 1ns/1ps
module tb_midi_uart_tx;

    logic       pll_clk_in = 1'b0;
    logic       rst        = 1'b1;
    logic       midi_clock = 1'b0;
    logic       keep_alive = 1'b0;
    logic       midi_rst   = 1'b0;
    logic [7:0] s_data     = '0;
    logic       s_valid    = 1'b0;
    logic       s_ready;
    logic       tx_out;
    logic       busy;
    logic [4:0] fifo_level;
    logic       sense_sent;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int sense_cnt = 0;
    int low_cnt   = 0;
    bit mc_run    = 1'b1;

    midi_uart_tx #(.FIFO_DEPTH_LOG2(4)) dut (
        .pll_clk_in (pll_clk_in),
        .rst        (rst),
        .midi_clock (midi_clock),
        .keep_alive (keep_alive),
        .midi_rst   (midi_rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_level (fifo_level),
        .sense_sent (sense_sent)
    );

    always #5 pll_clk_in = ~pll_clk_in;
    always @(posedge pll_clk_in) cyc <= cyc + 1;

    // 31.25 kHz bit clock: 256 system cycles per period, held low while mc_run is clear.
    always begin
        repeat (128) @(negedge pll_clk_in);
        midi_clock = mc_run ? ~midi_clock : 1'b0;
    end

    always @(negedge pll_clk_in) begin
        if (sense_sent) sense_cnt <= sense_cnt + 1;
        if (!tx_out)    low_cnt   <= low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge pll_clk_in);
        s_data  = b;
        s_valid = 1'b1;
        @(negedge pll_clk_in);
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx_out !== 1'b0 && n < 4000) begin
            @(negedge pll_clk_in);
            n++;
        end
        check({tag, "_start"}, 32'(tx_out === 1'b0), 32'd1);
        start_cyc = cyc;
    endtask

    // Samples nbits bit-centres from the next start bit; bit i of got is the i-th bit on the line.
    task automatic recv(input string tag, input int nbits, input logic [29:0] exp);
        logic [29:0] got = '0;
        wait_start(tag);
        repeat (128) @(negedge pll_clk_in);
        for (int i = 0; i < nbits; i++) begin
            got[i] = tx_out;
            if (i != nbits - 1) repeat (256) @(negedge pll_clk_in);
        end
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic wait_busy_low(input string tag, input int exp_dur);
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge pll_clk_in);
            n++;
        end
        check(tag, 32'(cyc - start_cyc), 32'(exp_dur));
    endtask

    task automatic pulse_ka();
        @(negedge pll_clk_in);
        keep_alive = 1'b1;
        repeat (20) @(negedge pll_clk_in);
        keep_alive = 1'b0;
    endtask

    initial begin
        int s_base;
        int l_base;
        int n;

        // Reset values
        repeat (5) @(negedge pll_clk_in);
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_sense", 32'(sense_sent), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge pll_clk_in);
        check("idle_s_ready", 32'(s_ready), 32'd1);

        // Single byte 0x90: line reads 0,0,0,0,0,1,0,0,1,1
        send(8'h90);
        check("single_level", 32'(fifo_level), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        recv("single_bits", 10, {20'b0, frame(8'h90)});
        wait_busy_low("single_busy_len", 2560);
        check("single_level_end", 32'(fifo_level), 32'd0);

        // Back-to-back: three writes on consecutive cycles, 30 contiguous bits
        repeat (10) @(negedge pll_clk_in);
        s_valid = 1'b1;
        s_data  = 8'h90;
        @(negedge pll_clk_in);
        s_data  = 8'h3C;
        @(negedge pll_clk_in);
        s_data  = 8'h7F;
        @(negedge pll_clk_in);
        s_valid = 1'b0;
        recv("b2b_bits", 30, {frame(8'h7F), frame(8'h3C), frame(8'h90)});
        wait_busy_low("b2b_busy_len", 7680);

        // FIFO full with the bit clock stopped
        mc_run = 1'b0;
        repeat (600) @(negedge pll_clk_in);
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 8'h10 + 8'(i);
            @(negedge pll_clk_in);
        end
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_s_ready", 32'(s_ready), 32'd0);
        s_data = 8'hEE;
        repeat (20) @(negedge pll_clk_in);
        check("full_held_level", 32'(fifo_level), 32'd16);
        mc_run = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 400) begin
            @(negedge pll_clk_in);
            n++;
        end
        check("full_after_pop", 32'(fifo_level), 32'd15);
        @(negedge pll_clk_in);
        s_valid = 1'b0;
        check("full_17th_in", 32'(fifo_level), 32'd16);
        recv("full_first", 10, {20'b0, frame(8'h10)});
        @(negedge pll_clk_in);
        rst = 1'b1;
        repeat (2) @(negedge pll_clk_in);
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_tx_out", 32'(tx_out), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge pll_clk_in);

        // Mid-frame midi_rst during data bit 3 of 0xA5 (that bit is 0)
        send(8'hA5);
        wait_start("mrst");
        repeat (128 + 4 * 256) @(negedge pll_clk_in);
        check("mrst_bit3", 32'(tx_out), 32'd0);
        send(8'h11);
        check("mrst_level_pre", 32'(fifo_level), 32'd1);
        midi_rst = 1'b1;
        repeat (3) @(negedge pll_clk_in);
        check("mrst_tx_out", 32'(tx_out), 32'd1);
        s_valid = 1'b1;
        s_data  = 8'h22;
        repeat (5) @(negedge pll_clk_in);
        check("mrst_level", 32'(fifo_level), 32'd0);
        check("mrst_s_ready", 32'(s_ready), 32'd0);
        s_valid  = 1'b0;
        midi_rst = 1'b0;
        repeat (10) @(negedge pll_clk_in);
        check("mrst_release_ready", 32'(s_ready), 32'd1);
        send(8'h3C);
        recv("mrst_after", 10, {20'b0, frame(8'h3C)});
        repeat (300) @(negedge pll_clk_in);

`ifdef MIDI_TX_ACTIVE_SENSE_EN
        // Two quiet keep-alive pulses: one 0xFE frame and one sense_sent cycle each
        rst = 1'b1;
        repeat (2) @(negedge pll_clk_in);
        rst = 1'b0;
        s_base = sense_cnt;
        pulse_ka();
        recv("as1_bits", 10, {20'b0, frame(8'hFE)});
        check("as1_sense", 32'(sense_cnt - s_base), 32'd1);
        repeat (300) @(negedge pll_clk_in);
        pulse_ka();
        recv("as2_bits", 10, {20'b0, frame(8'hFE)});
        check("as2_sense", 32'(sense_cnt - s_base), 32'd2);
        repeat (300) @(negedge pll_clk_in);

        // A data byte between pulses suppresses the next 0xFE
        send(8'h90);
        recv("supp_byte", 10, {20'b0, frame(8'h90)});
        repeat (300) @(negedge pll_clk_in);
        s_base = sense_cnt;
        l_base = low_cnt;
        pulse_ka();
        repeat (3000) @(negedge pll_clk_in);
        check("supp_sense", 32'(sense_cnt - s_base), 32'd0);
        check("supp_line", 32'(low_cnt - l_base), 32'd0);
`else
        // Without active sensing keep_alive must be ignored
        s_base = sense_cnt;
        l_base = low_cnt;
        pulse_ka();
        repeat (3000) @(negedge pll_clk_in);
        check("ka_off_sense", 32'(sense_cnt - s_base), 32'd0);
        check("ka_off_line", 32'(low_cnt - l_base), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
